// File: rtl/spec_acc_readout_pkg.sv
// Shared constants, FSM encoding and read-pacing helper for the spectrum accumulator readout.
package spec_acc_readout_pkg;

  localparam logic [15:0] SYNC_WORD = 16'hA5A5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR0   = 3'd1,
    ST_HDR1   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  // Words that will occupy the skid FIFO next cycle: current occupancy, less this
  // cycle's pop, plus the RAM read whose data lands next cycle.
  function automatic logic [2:0] fifo_commit(input logic [1:0] cnt, input logic pop,
                                             input logic inflight);
    return {1'b0, cnt} - {2'b00, pop} + {2'b00, inflight};
  endfunction

endpackage

// File: rtl/spec_acc_readout_skid_fifo.sv
// Two-entry FIFO between the RAM read port and the output lanes; flushed only by reset.
module spec_acc_readout_skid_fifo #(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         push;
  logic         pop;

  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign pop         = out_valid_o && out_ready_i;
  assign push        = in_valid_i && (count_q != 2'd2);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/spec_acc_readout.sv
// Streams a header plus N_BINS accumulated bins from the accumulator RAM onto the y0/y0z lanes,
// optionally zero-clearing each bin once its read data has been captured.
module spec_acc_readout
  import spec_acc_readout_pkg::*;
#(
  parameter int N_BINS         = 512,
  parameter int ADDR_W         = 9,
  parameter int ACC_W          = 32,
  parameter int CLR_AFTER_READ = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              acc_done_i,
  input  logic [15:0]       avg_cnt_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [ACC_W-1:0]  rd_data_i,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic [15:0]       y0_o,
  output logic [15:0]       y0z_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              frame_start_o,
  output logic              frame_last_o,
  output logic              busy_o,
  output logic              overrun_o,
  input  logic              clr_status_i,
  output state_t            dbg_state_o
);

  // Handshake: a word transfers on any clock edge where out_valid_o && out_ready_i; while
  // out_valid_o is high and out_ready_i low, y0/y0z/frame_start/frame_last hold their values.

  state_t            state_q;
  logic [15:0]       avg_q;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              overrun_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cap_addr_q;
  logic              inflight_q;

  logic              fifo_valid;
  logic [ACC_W:0]    fifo_data;
  logic [1:0]        fifo_cnt;
  logic              fifo_pop;
  logic              streaming;
  logic              rd_en;
  logic              frame_done;

  assign streaming  = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign fifo_pop   = streaming && fifo_valid && out_ready_i;
  assign rd_en      = (state_q == ST_STREAM) && (fifo_commit(fifo_cnt, fifo_pop, inflight_q) < 3'd2);
  assign frame_done = (state_q == ST_DRAIN) && !inflight_q && (fifo_cnt == 2'd0);
  assign addr_d     = rd_en ? addr_q + 1'b1 : addr_q;
  assign frame_cnt_d = frame_cnt_q + {15'd0, frame_done};

  spec_acc_readout_skid_fifo #(.W(ACC_W + 1)) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (inflight_q),
    .in_data_i   ({cap_addr_q == ADDR_W'(N_BINS - 1), rd_data_i}),
    .out_valid_o (fifo_valid),
    .out_ready_i (fifo_pop),
    .out_data_o  (fifo_data),
    .count_o     (fifo_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      avg_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (acc_done_i && state_q != ST_IDLE) overrun_q <= 1'b1;
      else if (clr_status_i)                overrun_q <= 1'b0;
      case (state_q)
        ST_IDLE:   if (acc_done_i) begin
                     avg_q   <= avg_cnt_i;
                     state_q <= ST_HDR0;
                   end
        ST_HDR0:   if (out_ready_i) state_q <= ST_HDR1;
        ST_HDR1:   if (out_ready_i) state_q <= ST_STREAM;
        ST_STREAM: if (rd_en && addr_q == ADDR_W'(N_BINS - 1)) state_q <= ST_DRAIN;
        ST_DRAIN:  if (frame_done) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      frame_cnt_q <= '0;
      addr_q      <= '0;
      cap_addr_q  <= '0;
      inflight_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      addr_q      <= addr_d;
      inflight_q  <= rd_en;
      if (rd_en) cap_addr_q <= addr_q;
    end
  end

  // The clear write lands on the same cycle the read data enters the FIFO, so each bin is
  // zeroed exactly once and only after its value is safe.
  assign clr_we_o    = (CLR_AFTER_READ != 0) && inflight_q;
  assign clr_addr_o  = clr_we_o ? cap_addr_q : '0;
  assign rd_en_o     = rd_en;
  assign rd_addr_o   = addr_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign overrun_o   = overrun_q;
  assign dbg_state_o = state_q;

  always_comb begin
    out_valid_o   = 1'b0;
    y0_o          = '0;
    y0z_o         = '0;
    frame_start_o = 1'b0;
    frame_last_o  = 1'b0;
    case (state_q)
      ST_HDR0: begin
        out_valid_o   = 1'b1;
        y0_o          = SYNC_WORD;
        y0z_o         = frame_cnt_q;
        frame_start_o = 1'b1;
      end
      ST_HDR1: begin
        out_valid_o = 1'b1;
        y0_o        = 16'(N_BINS);
        y0z_o       = avg_q;
      end
      ST_STREAM, ST_DRAIN: begin
        out_valid_o = fifo_valid;
        if (fifo_valid) begin
          y0_o         = fifo_data[ACC_W-1:16];
          y0z_o        = fifo_data[15:0];
          frame_last_o = fifo_data[ACC_W];
        end
      end
      default: ;
    endcase
  end

endmodule
